ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Shares the single-port data RAM between the pipeline's memory stage (CPU port) and an external loader/readout port (EXT port). It grants at most one access per cycle, drives the RAM address, data and write-enable lines, and raises a stall to the pipeline while the CPU request is held off. It tracks in-flight reads so the RAM output is flagged valid to the requester that issued each read. It sits between ExecuteMemory_register and the RAM, replacing their direct connection.

## Interface
- DATA_W, 16, data width
- ADDR_W, 16, address width
- RD_LATENCY, 1, RAM read latency in cycles (legal 1..3)
- MAX_WAIT, 4, cycles EXT may be denied before it is forced through (legal ≥1; used only with the starvation guard)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU access request, held until granted
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access issued this cycle
- cpu_stall  out  1  freeze PC/pipeline registers
- cpu_rvalid  out  1  ram_q holds CPU read data
- ext_req, ext_we, ext_addr, ext_wdata  in  1/1/ADDR_W/DATA_W  EXT equivalents
- ext_gnt  out  1  EXT access issued this cycle
- ext_rvalid  out  1  ram_q holds EXT read data
- ram_address  out  ADDR_W  to RAM address
- ram_data  out  DATA_W  to RAM data
- ram_wren  out  1  to RAM wren
- ram_q  in  DATA_W  RAM output, forwarded unchanged as rdata
- cpu_rdata, ext_rdata  out  DATA_W  equal to ram_q

## Operation
- Grant decision is combinational within the cycle. At most one of cpu_gnt/ext_gnt is high per cycle.
- Default priority: CPU over EXT.
- RAM lines follow the granted port: address, wdata and wren = req_we. With no grant, ram_wren = 0 and address/data hold the CPU values.
- cpu_stall = cpu_req & ~cpu_gnt.
- Read tag pipeline: RD_LATENCY-stage shift register carrying {valid, owner}. A stage is loaded on each granted read (we = 0). Writes produce no rvalid.
- Starvation counter (guard compiled in):
  - wait_cnt increments each cycle ext_req & ~ext_gnt, saturating at MAX_WAIT.
  - It clears on ext_gnt or when ext_req is low.
  - When wait_cnt == MAX_WAIT and ext_req is high, EXT wins over CPU that cycle.
- Requesters must hold req/we/addr/wdata stable until gnt. A request deasserted before grant is dropped with no side effect.

## Timing
- Grant latency: 0 cycles when uncontended; throughput is 1 access per cycle.
- Read data: rvalid asserts exactly RD_LATENCY cycles after the gnt cycle of a read, for one cycle. Back-to-back reads yield back-to-back rvalids in issue order.
- Writes take effect at the clock edge ending the gnt cycle.
- Read issued in the cycle after a write to the same address returns the new data (RAM behaviour; the arbiter does not reorder).
- Reset, including mid-operation:
  - Tag pipeline and wait_cnt clear next edge, so in-flight rvalids are suppressed.
  - While reset is high: cpu_gnt = ext_gnt = 0, ram_wren = 0, rvalids = 0, cpu_stall = 0.
- Simultaneous cpu_req and ext_req: CPU granted unless the guard forces EXT. When EXT is forced, cpu_stall is high for that cycle.

## Configuration
- ARB_STARVE_GUARD_EN defined: the wait_cnt starvation guard above is built. EXT waits at most MAX_WAIT cycles under continuous CPU traffic.
- ARB_STARVE_GUARD_EN undefined: strict CPU priority, no wait_cnt register. EXT may be denied indefinitely, and MAX_WAIT is ignored.

## Test plan
- Reset held 3 cycles with both reqs high -> no gnt, ram_wren=0, no rvalid. After release, CPU granted in the first cycle.
- CPU write 0x0010←0xBEEF, then CPU read 0x0010 (RD_LATENCY=1) -> cpu_gnt both cycles, cpu_stall=0, cpu_rvalid one cycle after the read gnt with cpu_rdata=0xBEEF, ext_rvalid=0.
- EXT read alone, then CPU and EXT read same cycle -> EXT granted immediately. In the contended cycle cpu_gnt=1, ext_gnt=0, and ext is granted the next cycle. rvalids arrive in issue order with correct owner.
- Guard on, MAX_WAIT=4, cpu_req held continuously, ext_req high -> ext_gnt on the 5th cycle. cpu_stall=1 exactly that cycle, then wait_cnt=0 and CPU resumes.
- Guard off, same stimulus for 50 cycles -> ext_gnt never asserts, cpu_stall never asserts.
- RD_LATENCY=3, three back-to-back reads (CPU, EXT, CPU), reset asserted one cycle after the last gnt -> first rvalid still emitted if its edge precedes reset. All later rvalids suppressed, with none after reset is released.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ============================================================================
//  Module   : ram_port_arbiter
//  Purpose  : Single-port RAM arbiter between CPU memory stage and EXT port,
//             with read-owner tag pipeline. Optional macro: ARB_STARVE_GUARD_EN
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_port_arbiter #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int RD_LATENCY = 1,
    parameter int MAX_WAIT   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    logic w_force_ext;
    logic w_cpu_gnt;
    logic w_ext_gnt;
    logic w_rd_issue;

    logic [RD_LATENCY-1:0] r_tag_vld;
    logic [RD_LATENCY-1:0] r_tag_ext;

`ifdef ARB_STARVE_GUARD_EN
    localparam int                c_CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [c_CNT_W-1:0] c_MAX  = c_CNT_W'(MAX_WAIT);

    logic [c_CNT_W-1:0] r_wait_cnt;

    // Counts consecutive denied EXT cycles; a saturated count hands EXT the RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (!ext_req || w_ext_gnt) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != c_MAX) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign w_force_ext = ext_req && (r_wait_cnt == c_MAX);
`else
    assign w_force_ext = 1'b0;
`endif

    assign w_cpu_gnt = !reset && cpu_req && !w_force_ext;
    assign w_ext_gnt = !reset && ext_req && (!cpu_req || w_force_ext);

    assign cpu_gnt   = w_cpu_gnt;
    assign ext_gnt   = w_ext_gnt;
    assign cpu_stall = !reset && cpu_req && !w_cpu_gnt;

    // Idle cycles leave the CPU values on the RAM bus with writes disabled.
    assign ram_address = w_ext_gnt ? ext_addr  : cpu_addr;
    assign ram_data    = w_ext_gnt ? ext_wdata : cpu_wdata;
    assign ram_wren    = (w_cpu_gnt && cpu_we) || (w_ext_gnt && ext_we);

    assign w_rd_issue = (w_cpu_gnt && !cpu_we) || (w_ext_gnt && !ext_we);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag_vld <= '0;
            r_tag_ext <= '0;
        end else begin
            r_tag_vld[0] <= w_rd_issue;
            r_tag_ext[0] <= w_ext_gnt;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_ext[i] <= r_tag_ext[i-1];
            end
        end
    end

    assign cpu_rvalid = !reset && r_tag_vld[RD_LATENCY-1] && !r_tag_ext[RD_LATENCY-1];
    assign ext_rvalid = !reset && r_tag_vld[RD_LATENCY-1] &&  r_tag_ext[RD_LATENCY-1];

    assign cpu_rdata = ram_q;
    assign ext_rdata = ram_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// ============================================================================
//  Module   : tb_ram_port_arbiter
//  Purpose  : Directed self-checking bench for ram_port_arbiter (latency 1 and 3)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ram_port_arbiter;

`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        cpu_req, cpu_we, ext_req, ext_we;
    logic [15:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;

    logic        cpu_gnt1, cpu_stall1, cpu_rvalid1, ext_gnt1, ext_rvalid1, ram_wren1;
    logic [15:0] cpu_rdata1, ext_rdata1, ram_address1, ram_data1, ram_q1;
    logic        cpu_gnt3, cpu_stall3, cpu_rvalid3, ext_gnt3, ext_rvalid3, ram_wren3;
    logic [15:0] cpu_rdata3, ext_rdata3, ram_address3, ram_data3, ram_q3;

    int checks   = 0;
    int failures = 0;

    ram_port_arbiter #(.DATA_W(16), .ADDR_W(16), .RD_LATENCY(1), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt1), .cpu_stall(cpu_stall1), .cpu_rvalid(cpu_rvalid1), .cpu_rdata(cpu_rdata1),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt1), .ext_rvalid(ext_rvalid1), .ext_rdata(ext_rdata1),
        .ram_address(ram_address1), .ram_data(ram_data1), .ram_wren(ram_wren1), .ram_q(ram_q1)
    );

    ram_port_arbiter #(.DATA_W(16), .ADDR_W(16), .RD_LATENCY(3), .MAX_WAIT(4)) dut3 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt3), .cpu_stall(cpu_stall3), .cpu_rvalid(cpu_rvalid3), .cpu_rdata(cpu_rdata3),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt3), .ext_rvalid(ext_rvalid3), .ext_rdata(ext_rdata3),
        .ram_address(ram_address3), .ram_data(ram_data3), .ram_wren(ram_wren3), .ram_q(ram_q3)
    );

    // Behavioural single-port RAMs with 1- and 3-cycle read latency.
    logic [15:0] mem1 [0:255];
    logic [15:0] mem3 [0:255];
    logic [15:0] s3a, s3b;

    always @(posedge clk) begin
        if (ram_wren1) mem1[ram_address1[7:0]] <= ram_data1;
        ram_q1 <= mem1[ram_address1[7:0]];
        if (ram_wren3) mem3[ram_address3[7:0]] <= ram_data3;
        s3a    <= mem3[ram_address3[7:0]];
        s3b    <= s3a;
        ram_q3 <= s3b;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 1'b0; ext_req = 1'b0; cpu_we = 1'b0; ext_we = 1'b0;
    endtask

    task automatic test_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 16'h0020;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({cpu_gnt1, ext_gnt1, ram_wren1, cpu_rvalid1, ext_rvalid1, cpu_stall1} !== 6'b0) begin
                failures++;
                $display("FAIL reset_outputs_l1 cyc=%0d got=%b exp=000000", i,
                         {cpu_gnt1, ext_gnt1, ram_wren1, cpu_rvalid1, ext_rvalid1, cpu_stall1});
            end
            checks++;
            if ({cpu_gnt3, ext_gnt3, ram_wren3, cpu_rvalid3, ext_rvalid3, cpu_stall3} !== 6'b0) begin
                failures++;
                $display("FAIL reset_outputs_l3 cyc=%0d got=%b exp=000000", i,
                         {cpu_gnt3, ext_gnt3, ram_wren3, cpu_rvalid3, ext_rvalid3, cpu_stall3});
            end
            tick();
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({cpu_gnt1, ext_gnt1, cpu_stall1} !== 3'b100) begin
            failures++;
            $display("FAIL post_reset_grant got=%b exp=100", {cpu_gnt1, ext_gnt1, cpu_stall1});
        end
        tick();
        idle();
        repeat (4) tick();
    endtask

    task automatic test_idle_bus();
        cpu_we = 1'b1; cpu_addr = 16'h0055; cpu_wdata = 16'hAAAA;
        ext_addr = 16'h0066; ext_wdata = 16'h7777;
        @(negedge clk);
        checks++;
        if ({cpu_gnt1, ext_gnt1, ram_wren1, cpu_stall1, ram_address1, ram_data1} !== {4'b0000, 16'h0055, 16'hAAAA}) begin
            failures++;
            $display("FAIL idle_bus got gnt/gnt/wren/stall=%b addr=%h data=%h exp=0000 0055 aaaa",
                     {cpu_gnt1, ext_gnt1, ram_wren1, cpu_stall1}, ram_address1, ram_data1);
        end
        tick();
        idle();
    endtask

    task automatic test_cpu_write_read();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF;
        @(negedge clk);
        checks++;
        if ({cpu_gnt1, cpu_stall1, ram_wren1, ram_address1, ram_data1} !== {3'b101, 16'h0010, 16'hBEEF}) begin
            failures++;
            $display("FAIL cpu_write got gnt/stall/wren=%b addr=%h data=%h exp=101 0010 beef",
                     {cpu_gnt1, cpu_stall1, ram_wren1}, ram_address1, ram_data1);
        end
        tick();
        cpu_we = 1'b0;
        @(negedge clk);
        checks++;
        if ({cpu_gnt1, cpu_stall1, ram_wren1, cpu_rvalid1} !== 4'b1000) begin
            failures++;
            $display("FAIL cpu_read_issue got=%b exp=1000", {cpu_gnt1, cpu_stall1, ram_wren1, cpu_rvalid1});
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if ({cpu_rvalid1, ext_rvalid1, cpu_rdata1} !== {2'b10, 16'hBEEF}) begin
            failures++;
            $display("FAIL cpu_read_data got rv=%b data=%h exp=10 beef", {cpu_rvalid1, ext_rvalid1}, cpu_rdata1);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({cpu_rvalid1, ext_rvalid1} !== 2'b00) begin
            failures++;
            $display("FAIL cpu_rvalid_single got=%b exp=00", {cpu_rvalid1, ext_rvalid1});
        end
        tick();
    endtask

    task automatic test_ext_contend();
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 16'h0020; ext_wdata = 16'h1234;
        @(negedge clk);
        checks++;
        if ({cpu_gnt1, ext_gnt1, ram_wren1, ram_address1, ram_data1} !== {3'b011, 16'h0020, 16'h1234}) begin
            failures++;
            $display("FAIL ext_write got gnt/gnt/wren=%b addr=%h data=%h exp=011 0020 1234",
                     {cpu_gnt1, ext_gnt1, ram_wren1}, ram_address1, ram_data1);
        end
        tick();
        ext_we = 1'b0;
        @(negedge clk);
        checks++;
        if ({cpu_gnt1, ext_gnt1, ram_wren1} !== 3'b010) begin
            failures++;
            $display("FAIL ext_read_alone got=%b exp=010", {cpu_gnt1, ext_gnt1, ram_wren1});
        end
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        @(negedge clk);
        checks++;
        if ({cpu_gnt1, ext_gnt1, cpu_stall1, ram_address1} !== {3'b100, 16'h0010}) begin
            failures++;
            $display("FAIL contend_cpu_wins got gnt/gnt/stall=%b addr=%h exp=100 0010",
                     {cpu_gnt1, ext_gnt1, cpu_stall1}, ram_address1);
        end
        checks++;
        if ({cpu_rvalid1, ext_rvalid1, ext_rdata1} !== {2'b01, 16'h1234}) begin
            failures++;
            $display("FAIL ext_read_data got rv=%b data=%h exp=01 1234", {cpu_rvalid1, ext_rvalid1}, ext_rdata1);
        end
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({cpu_gnt1, ext_gnt1, ram_address1} !== {2'b01, 16'h0020}) begin
            failures++;
            $display("FAIL contend_ext_next got gnt=%b addr=%h exp=01 0020", {cpu_gnt1, ext_gnt1}, ram_address1);
        end
        checks++;
        if ({cpu_rvalid1, ext_rvalid1, cpu_rdata1} !== {2'b10, 16'hBEEF}) begin
            failures++;
            $display("FAIL contend_cpu_rdata got rv=%b data=%h exp=10 beef", {cpu_rvalid1, ext_rvalid1}, cpu_rdata1);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if ({cpu_rvalid1, ext_rvalid1, ext_rdata1} !== {2'b01, 16'h1234}) begin
            failures++;
            $display("FAIL contend_ext_rdata got rv=%b data=%h exp=01 1234", {cpu_rvalid1, ext_rvalid1}, ext_rdata1);
        end
        tick();
        repeat (3) tick();
    endtask

    task automatic test_starvation();
        int ncyc;
        logic [2:0] exp;
        ncyc = GUARD ? 8 : 50;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 16'h0020;
        for (int i = 0; i < ncyc; i++) begin
            exp = (GUARD && i == 4) ? 3'b011 : 3'b100;
            @(negedge clk);
            checks++;
            if ({cpu_gnt1, ext_gnt1, cpu_stall1} !== exp) begin
                failures++;
                $display("FAIL starve cyc=%0d got cpu_gnt/ext_gnt/stall=%b exp=%b", i,
                         {cpu_gnt1, ext_gnt1, cpu_stall1}, exp);
            end
            tick();
        end
        idle();
        repeat (4) tick();
    endtask

    task automatic test_latency3_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        @(negedge clk);
        checks++;
        if ({cpu_gnt3, cpu_rvalid3, ext_rvalid3} !== 3'b100) begin
            failures++;
            $display("FAIL l3_issue0 got=%b exp=100", {cpu_gnt3, cpu_rvalid3, ext_rvalid3});
        end
        tick();
        cpu_req = 1'b0; ext_req = 1'b1; ext_we = 1'b0; ext_addr = 16'h0020;
        @(negedge clk);
        checks++;
        if ({ext_gnt3, cpu_rvalid3, ext_rvalid3} !== 3'b100) begin
            failures++;
            $display("FAIL l3_issue1 got=%b exp=100", {ext_gnt3, cpu_rvalid3, ext_rvalid3});
        end
        tick();
        ext_req = 1'b0; cpu_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({cpu_gnt3, cpu_rvalid3, ext_rvalid3} !== 3'b100) begin
            failures++;
            $display("FAIL l3_issue2 got=%b exp=100", {cpu_gnt3, cpu_rvalid3, ext_rvalid3});
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if ({cpu_rvalid3, ext_rvalid3, cpu_rdata3} !== {2'b10, 16'hBEEF}) begin
            failures++;
            $display("FAIL l3_first_rvalid got rv=%b data=%h exp=10 beef", {cpu_rvalid3, ext_rvalid3}, cpu_rdata3);
        end
        tick();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({cpu_rvalid3, ext_rvalid3} !== 2'b00) begin
            failures++;
            $display("FAIL l3_rvalid_in_reset got=%b exp=00", {cpu_rvalid3, ext_rvalid3});
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({cpu_rvalid3, ext_rvalid3} !== 2'b00) begin
                failures++;
                $display("FAIL l3_rvalid_after_reset cyc=%0d got=%b exp=00", i, {cpu_rvalid3, ext_rvalid3});
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
        test_reset();
        test_idle_bus();
        test_cpu_write_read();
        test_ext_contend();
        test_starvation();
        test_latency3_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
